mem_bus_arbiter: RTL and testbench

Two-master, one-slave arbiter that lets the CPU's instruction bus (ibus) and data bus (dbus) share a single 64-bit memory port. It sits between the CPU core and the memory/cache interface. It grants the port to one master at a time and holds the grant until that transaction's `data_ok`. It routes the slave response back to the granted master only, and alternates priority when both masters contend.

---
 rtl/mem_bus_arbiter.sv | 127 ++++++++++++
 tb/tb_mem_bus_arbiter.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// Two-master (ibus/dbus) to one-slave memory port arbiter with round-robin
// priority on contention; the grant is held from arbitration until m_data_ok.
module mem_bus_arbiter #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              i_valid,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_addr_ok,
    output logic              i_data_ok,
    output logic [31:0]       i_data,

    input  logic              d_valid,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [2:0]        d_size,
    input  logic [7:0]        d_strobe,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_addr_ok,
    output logic              d_data_ok,
    output logic [DATA_W-1:0] d_rdata,

    output logic              m_valid,
    output logic [ADDR_W-1:0] m_addr,
    output logic [2:0]        m_size,
    output logic [7:0]        m_strobe,
    output logic [DATA_W-1:0] m_wdata,
    input  logic              m_addr_ok,
    input  logic              m_data_ok,
    input  logic [DATA_W-1:0] m_rdata
);

    // Handshake: a master raises valid and holds it until its data_ok; addr_ok
    // and data_ok are single-cycle slave strobes that may coincide, and only the
    // granted master ever sees them.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   last_d;
    logic   isel;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= IDLE;
            last_d <= 1'b0;
            isel   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && state_nxt == GNT_I) begin
                isel <= i_addr[2];
            end
            if (state == GNT_I && m_data_ok) begin
                last_d <= 1'b0;
            end
            if (state == GNT_D && m_data_ok) begin
                last_d <= 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (i_valid && d_valid) begin
                    state_nxt = last_d ? GNT_I : GNT_D;
                end else if (i_valid) begin
                    state_nxt = GNT_I;
                end else if (d_valid) begin
                    state_nxt = GNT_D;
                end
            end
            GNT_I, GNT_D: begin
                if (m_data_ok) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are forced quiet while reset is asserted, even mid-grant.
    always_comb begin
        m_valid   = 1'b0;
        m_addr    = '0;
        m_size    = 3'd0;
        m_strobe  = 8'd0;
        m_wdata   = '0;
        i_addr_ok = 1'b0;
        i_data_ok = 1'b0;
        i_data    = 32'd0;
        d_addr_ok = 1'b0;
        d_data_ok = 1'b0;
        d_rdata   = '0;
        if (rst) begin
            case (state)
                GNT_I: begin
                    m_valid   = i_valid;
                    m_addr    = i_addr;
                    m_size    = 3'd2;
                    i_addr_ok = m_addr_ok;
                    i_data_ok = m_data_ok;
                    i_data    = isel ? m_rdata[63:32] : m_rdata[31:0];
                end
                GNT_D: begin
                    m_valid   = d_valid;
                    m_addr    = d_addr;
                    m_size    = d_size;
                    m_strobe  = d_strobe;
                    m_wdata   = d_wdata;
                    d_addr_ok = m_addr_ok;
                    d_data_ok = m_data_ok;
                    d_rdata   = m_rdata;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: a grant-owner model checked every cycle
// plus literal expectations for each scenario.
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_valid;
    logic [63:0] i_addr;
    logic        i_addr_ok, i_data_ok;
    logic [31:0] i_data;
    logic        d_valid;
    logic [63:0] d_addr;
    logic [2:0]  d_size;
    logic [7:0]  d_strobe;
    logic [63:0] d_wdata;
    logic        d_addr_ok, d_data_ok;
    logic [63:0] d_rdata;
    logic        m_valid;
    logic [63:0] m_addr;
    logic [2:0]  m_size;
    logic [7:0]  m_strobe;
    logic [63:0] m_wdata;
    logic        m_addr_ok, m_data_ok;
    logic [63:0] m_rdata;

    int checks = 0;
    int failures = 0;
    bit cmp_en = 1'b0;

    // Model: owner 0 = nobody, 1 = ibus, 2 = dbus.
    int owner = 0;
    bit mdl_last_d = 1'b0;
    bit mdl_half = 1'b0;

    int grant_q[$];

    mem_bus_arbiter dut (
        .clk(clk), .rst(rst),
        .i_valid(i_valid), .i_addr(i_addr), .i_addr_ok(i_addr_ok),
        .i_data_ok(i_data_ok), .i_data(i_data),
        .d_valid(d_valid), .d_addr(d_addr), .d_size(d_size), .d_strobe(d_strobe),
        .d_wdata(d_wdata), .d_addr_ok(d_addr_ok), .d_data_ok(d_data_ok),
        .d_rdata(d_rdata),
        .m_valid(m_valid), .m_addr(m_addr), .m_size(m_size), .m_strobe(m_strobe),
        .m_wdata(m_wdata), .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok),
        .m_rdata(m_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_slave();
        m_addr_ok = 1'b0;
        m_data_ok = 1'b0;
    endtask

    always @(posedge clk) begin
        if (!rst) begin
            owner      <= 0;
            mdl_last_d <= 1'b0;
            mdl_half   <= 1'b0;
        end else if (owner == 0) begin
            if (i_valid && d_valid) begin
                owner <= mdl_last_d ? 1 : 2;
                if (mdl_last_d) mdl_half <= i_addr[2];
            end else if (i_valid) begin
                owner    <= 1;
                mdl_half <= i_addr[2];
            end else if (d_valid) begin
                owner <= 2;
            end
        end else if (m_data_ok) begin
            owner      <= 0;
            mdl_last_d <= (owner == 2);
        end
    end

    always @(negedge clk) begin
        logic        e_mv, e_iao, e_ido, e_dao, e_ddo;
        logic [63:0] e_ma, e_mw, e_dr;
        logic [2:0]  e_ms;
        logic [7:0]  e_mst;
        logic [31:0] e_id;
        if (cmp_en) begin
            e_mv = 0; e_ma = 0; e_ms = 0; e_mst = 0; e_mw = 0;
            e_iao = 0; e_ido = 0; e_id = 0; e_dao = 0; e_ddo = 0; e_dr = 0;
            if (rst && owner == 1) begin
                e_mv = i_valid; e_ma = i_addr; e_ms = 3'd2;
                e_iao = m_addr_ok; e_ido = m_data_ok;
                e_id = mdl_half ? m_rdata[63:32] : m_rdata[31:0];
            end else if (rst && owner == 2) begin
                e_mv = d_valid; e_ma = d_addr; e_ms = d_size; e_mst = d_strobe;
                e_mw = d_wdata; e_dao = m_addr_ok; e_ddo = m_data_ok; e_dr = m_rdata;
            end
            check("m_valid", 64'(m_valid), 64'(e_mv));
            check("m_addr", m_addr, e_ma);
            check("m_size", 64'(m_size), 64'(e_ms));
            check("m_strobe", 64'(m_strobe), 64'(e_mst));
            check("m_wdata", m_wdata, e_mw);
            check("i_addr_ok", 64'(i_addr_ok), 64'(e_iao));
            check("i_data_ok", 64'(i_data_ok), 64'(e_ido));
            check("i_data", 64'(i_data), 64'(e_id));
            check("d_addr_ok", 64'(d_addr_ok), 64'(e_dao));
            check("d_data_ok", 64'(d_data_ok), 64'(e_ddo));
            check("d_rdata", d_rdata, e_dr);
        end
    end

    initial begin
        rst = 1'b0;
        i_valid = 1'b1; i_addr = 64'h8000_0000;
        d_valid = 1'b1; d_addr = 64'h8000_2000; d_size = 3'd3;
        d_strobe = 8'h00; d_wdata = 64'h0;
        m_addr_ok = 1'b0; m_data_ok = 1'b0; m_rdata = 64'h0;

        // Reset held three cycles with both masters requesting.
        tick();
        cmp_en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("rst_m_valid", 64'(m_valid), 64'd0);
            check("rst_oks", 64'({i_addr_ok, i_data_ok, d_addr_ok, d_data_ok}), 64'd0);
            tick();
        end
        rst = 1'b1;
        @(negedge clk);
        check("rel_idle_m_valid", 64'(m_valid), 64'd0);
        tick();
        @(negedge clk);
        check("rel_m_valid", 64'(m_valid), 64'd1);
        check("rel_m_addr", m_addr, 64'h8000_2000);
        tick();
        m_addr_ok = 1'b1; m_data_ok = 1'b1;
        tick();
        clear_slave();
        i_valid = 1'b0; d_valid = 1'b0;
        tick();

        // Single ibus fetch, upper word, data two cycles after m_valid.
        i_valid = 1'b1; i_addr = 64'h8000_0004;
        tick();
        m_addr_ok = 1'b1;
        @(negedge clk);
        check("if_m_size", 64'(m_size), 64'd2);
        check("if_m_strobe", 64'(m_strobe), 64'd0);
        tick();
        clear_slave();
        tick();
        m_data_ok = 1'b1; m_rdata = 64'h1234_5678_9ABC_DEF0;
        @(negedge clk);
        check("if_i_data", 64'(i_data), 64'h1234_5678);
        check("if_i_data_ok", 64'(i_data_ok), 64'd1);
        tick();
        clear_slave();
        i_valid = 1'b0;
        @(negedge clk);
        check("if_i_data_ok_once", 64'(i_data_ok), 64'd0);
        tick();

        // dbus store.
        d_valid = 1'b1; d_addr = 64'h8000_1000; d_strobe = 8'hFF;
        d_wdata = 64'hDEAD_BEEF_0000_0001; d_size = 3'd3;
        tick();
        @(negedge clk);
        check("st_m_addr", m_addr, 64'h8000_1000);
        check("st_m_strobe", 64'(m_strobe), 64'hFF);
        check("st_m_wdata", m_wdata, 64'hDEAD_BEEF_0000_0001);
        tick();
        m_addr_ok = 1'b1;
        tick();
        m_addr_ok = 1'b0; m_data_ok = 1'b1;
        @(negedge clk);
        check("st_d_data_ok", 64'(d_data_ok), 64'd1);
        check("st_i_data_ok", 64'(i_data_ok), 64'd0);
        tick();
        clear_slave();
        d_valid = 1'b0; d_strobe = 8'h00;
        tick();

        // Contention: reset first so round-robin starts with dbus.
        rst = 1'b0;
        tick();
        rst = 1'b1;
        i_valid = 1'b1; i_addr = 64'h8000_0040;
        d_valid = 1'b1; d_addr = 64'h8000_4000; d_size = 3'd3;
        for (int t = 0; t < 4; t++) begin
            tick();
            @(negedge clk);
            check("rr_granted", 64'(m_valid), 64'd1);
            grant_q.push_back((m_size == 3'd2) ? 0 : 1);
            tick();
            m_addr_ok = 1'b1; m_data_ok = 1'b1;
            tick();
            clear_slave();
            @(negedge clk);
            check("rr_idle_gap", 64'(m_valid), 64'd0);
        end
        check("rr_count", 64'(grant_q.size()), 64'd4);
        if (grant_q.size() == 4) begin
            check("rr_order0", 64'(grant_q[0]), 64'd1);
            check("rr_order1", 64'(grant_q[1]), 64'd0);
            check("rr_order2", 64'(grant_q[2]), 64'd1);
            check("rr_order3", 64'(grant_q[3]), 64'd0);
        end

        // Reset mid-dbus transaction, then a late response in IDLE.
        i_valid = 1'b0;
        tick();
        tick();
        m_addr_ok = 1'b1;
        rst = 1'b0;
        @(negedge clk);
        check("mr_d_addr_ok", 64'(d_addr_ok), 64'd0);
        check("mr_m_valid", 64'(m_valid), 64'd0);
        tick();
        rst = 1'b1; d_valid = 1'b0;
        m_addr_ok = 1'b0; m_data_ok = 1'b1; m_rdata = 64'h5555_6666_7777_8888;
        @(negedge clk);
        check("mr_late_d_data_ok", 64'(d_data_ok), 64'd0);
        check("mr_late_i_data_ok", 64'(i_data_ok), 64'd0);
        tick();
        clear_slave();
        tick();

        // Single-cycle ibus grant, lower word.
        i_valid = 1'b1; i_addr = 64'h8000_0010;
        tick();
        m_addr_ok = 1'b1; m_data_ok = 1'b1; m_rdata = 64'h1234_5678_9ABC_DEF0;
        @(negedge clk);
        check("sc_i_data", 64'(i_data), 64'h9ABC_DEF0);
        check("sc_i_data_ok", 64'(i_data_ok), 64'd1);
        tick();
        clear_slave();
        i_valid = 1'b0;
        @(negedge clk);
        check("sc_idle", 64'(m_valid), 64'd0);
        tick();

        // ibus drops valid mid-grant: grant held, dbus kept isolated.
        i_valid = 1'b1; i_addr = 64'h8000_000C;
        tick();
        tick();
        i_valid = 1'b0;
        d_valid = 1'b1; d_addr = 64'h8000_3000; d_size = 3'd2; d_strobe = 8'h0F;
        d_wdata = 64'h0000_0000_AABB_CCDD;
        m_addr_ok = 1'b1;
        @(negedge clk);
        check("pv_m_valid", 64'(m_valid), 64'd0);
        check("pv_d_addr_ok", 64'(d_addr_ok), 64'd0);
        tick();
        m_addr_ok = 1'b0; m_data_ok = 1'b1; m_rdata = 64'hCAFE_0000_1111_2222;
        @(negedge clk);
        check("pv_i_data", 64'(i_data), 64'hCAFE_0000);
        check("pv_i_data_ok", 64'(i_data_ok), 64'd1);
        tick();
        clear_slave();
        @(negedge clk);
        check("pv_idle", 64'(m_valid), 64'd0);
        tick();
        @(negedge clk);
        check("pv_d_m_addr", m_addr, 64'h8000_3000);
        check("pv_d_m_strobe", 64'(m_strobe), 64'h0F);
        tick();
        m_data_ok = 1'b1;
        tick();
        clear_slave();
        d_valid = 1'b0;
        tick();
        tick();

        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
